// File: rtl/gpio_link_peer_if.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_link_peer_if
//  Description : Signal bundle for the GPIO byte-link responder. It carries
//                the inbound and outbound four-phase link channels, the local
//                host RX/TX port, the echo control and the status counters.
//  Revision    : 1.0  initial release
// ============================================================================
interface gpio_link_peer_if;
    // Link side (remote board)
    logic [7:0] lnk_din;
    logic       lnk_req;
    logic       lnk_ack;
    logic [7:0] lnk_dout;
    logic       lnk_oreq;
    logic       lnk_oack;
    // Host side
    logic       echo;
    logic       host_rd;
    logic [7:0] host_rdata;
    logic       host_rvalid;
    logic       host_wr;
    logic [7:0] host_wdata;
    logic       host_wfull;
    logic       tx_drop;
    logic       clr_drop;
    logic [7:0] rx_cnt;
    logic [7:0] tx_cnt;

    // The responder itself
    modport slave (
        input  lnk_din, lnk_req, lnk_oack, echo, host_rd, host_wr,
               host_wdata, clr_drop,
        output lnk_ack, lnk_dout, lnk_oreq, host_rdata, host_rvalid,
               host_wfull, tx_drop, rx_cnt, tx_cnt
    );

    // Remote board plus local host driving the responder
    modport master (
        output lnk_din, lnk_req, lnk_oack, echo, host_rd, host_wr,
               host_wdata, clr_drop,
        input  lnk_ack, lnk_dout, lnk_oreq, host_rdata, host_rvalid,
               host_wfull, tx_drop, rx_cnt, tx_cnt
    );
endinterface
`default_nettype wire

// File: rtl/gpio_link_peer.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_link_peer
//  Description : Hardware responder for the inter-board GPIO parallel byte
//                link. Receives bytes over a four-phase req/ack channel into
//                an RX FIFO, sends host bytes from a TX FIFO over a second
//                four-phase channel, and can echo received bytes back.
//  Revision    : 1.0  initial release
// ============================================================================
module gpio_link_peer #(
    parameter int DEPTH       = 16,
    parameter int AW          = 4,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic        clk,
    input  wire logic        reset,
    gpio_link_peer_if.slave  bus
);

    localparam logic [0:0] c_R_IDLE  = 1'b0;
    localparam logic [0:0] c_R_HOLD  = 1'b1;

    localparam logic [1:0] c_T_IDLE  = 2'd0;
    localparam logic [1:0] c_T_SETUP = 2'd1;
    localparam logic [1:0] c_T_REQ   = 2'd2;
    localparam logic [1:0] c_T_REL   = 2'd3;

    localparam logic [AW:0] c_PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] r_req_sync;
    logic [SYNC_STAGES-1:0] r_oack_sync;
    logic                   w_req_s;
    logic                   w_oack_s;

    logic [7:0]  r_rx_mem [DEPTH];
    logic [AW:0] r_rx_wp, r_rx_rp;
    logic [7:0]  r_tx_mem [DEPTH];
    logic [AW:0] r_tx_wp, r_tx_rp;

    logic [0:0]  r_rx_state;
    logic [1:0]  r_tx_state;
    logic        r_ack, r_oreq, r_drop;
    logic [7:0]  r_dout, r_rx_cnt, r_tx_cnt;

    logic w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
    logic w_rx_accept, w_rx_push, w_rx_pop, w_tx_push, w_tx_pop;
    logic w_host_push, w_host_drop;
    logic [7:0] w_tx_wdata;

    // Two-or-more-flop synchronizers on the asynchronous link strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_sync  <= '0;
            r_oack_sync <= '0;
        end else begin
            r_req_sync  <= {r_req_sync[SYNC_STAGES-2:0], bus.lnk_req};
            r_oack_sync <= {r_oack_sync[SYNC_STAGES-2:0], bus.lnk_oack};
        end
    end

    assign w_req_s  = r_req_sync[SYNC_STAGES-1];
    assign w_oack_s = r_oack_sync[SYNC_STAGES-1];

    // Full: pointers differ only in the wrap bit. Empty: pointers equal.
    assign w_rx_empty = (r_rx_wp == r_rx_rp);
    assign w_rx_full  = (r_rx_wp[AW] != r_rx_rp[AW]) &&
                        (r_rx_wp[AW-1:0] == r_rx_rp[AW-1:0]);
    assign w_tx_empty = (r_tx_wp == r_tx_rp);
    assign w_tx_full  = (r_tx_wp[AW] != r_tx_rp[AW]) &&
                        (r_tx_wp[AW-1:0] == r_tx_rp[AW-1:0]);

    // Echo selects the push target at the accept decision only, so a byte
    // already in R_HOLD is never re-routed.
    assign w_rx_accept = (r_rx_state == c_R_IDLE) && w_req_s &&
                         !(bus.echo ? w_tx_full : w_rx_full);
    assign w_rx_push   = w_rx_accept && !bus.echo;
    assign w_rx_pop    = bus.host_rd && !w_rx_empty;

    assign w_host_push = bus.host_wr && !bus.echo && !w_tx_full;
    assign w_host_drop = bus.host_wr && !bus.echo &&  w_tx_full;
    assign w_tx_push   = (w_rx_accept && bus.echo) || w_host_push;
    assign w_tx_wdata  = bus.echo ? bus.lnk_din : bus.host_wdata;
    assign w_tx_pop    = (r_tx_state == c_T_IDLE) && !w_tx_empty;

    // RX FIFO storage; a push into a full FIFO is only taken alongside a pop
    always_ff @(posedge clk) begin
        if (w_rx_push && (!w_rx_full || w_rx_pop))
            r_rx_mem[r_rx_wp[AW-1:0]] <= bus.lnk_din;
    end

    // RX FIFO pointers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_wp <= '0;
            r_rx_rp <= '0;
        end else begin
            if (w_rx_push && (!w_rx_full || w_rx_pop)) r_rx_wp <= r_rx_wp + c_PTR_ONE;
            if (w_rx_pop)                              r_rx_rp <= r_rx_rp + c_PTR_ONE;
        end
    end

    // TX FIFO storage
    always_ff @(posedge clk) begin
        if (w_tx_push && (!w_tx_full || w_tx_pop))
            r_tx_mem[r_tx_wp[AW-1:0]] <= w_tx_wdata;
    end

    // TX FIFO pointers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_wp <= '0;
            r_tx_rp <= '0;
        end else begin
            if (w_tx_push && (!w_tx_full || w_tx_pop)) r_tx_wp <= r_tx_wp + c_PTR_ONE;
            if (w_tx_pop)                              r_tx_rp <= r_tx_rp + c_PTR_ONE;
        end
    end

    // Inbound handshake: accept when the target has room, hold ack until req drops
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_state <= c_R_IDLE;
            r_ack      <= 1'b0;
            r_rx_cnt   <= 8'd0;
        end else begin
            case (r_rx_state)
                c_R_IDLE: begin
                    if (w_rx_accept) begin
                        r_ack      <= 1'b1;
                        r_rx_cnt   <= r_rx_cnt + 8'd1;
                        r_rx_state <= c_R_HOLD;
                    end
                end
                c_R_HOLD: begin
                    if (!w_req_s) begin
                        r_ack      <= 1'b0;
                        r_rx_state <= c_R_IDLE;
                    end
                end
                default: r_rx_state <= c_R_IDLE;
            endcase
        end
    end

    // Outbound handshake: load, one setup cycle, req until ack, wait ack release
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state <= c_T_IDLE;
            r_oreq     <= 1'b0;
            r_dout     <= 8'd0;
            r_tx_cnt   <= 8'd0;
        end else begin
            case (r_tx_state)
                c_T_IDLE: begin
                    if (w_tx_pop) begin
                        r_dout     <= r_tx_mem[r_tx_rp[AW-1:0]];
                        r_tx_state <= c_T_SETUP;
                    end
                end
                c_T_SETUP: begin
                    r_oreq     <= 1'b1;
                    r_tx_state <= c_T_REQ;
                end
                c_T_REQ: begin
                    if (w_oack_s) begin
                        r_oreq     <= 1'b0;
                        r_tx_cnt   <= r_tx_cnt + 8'd1;
                        r_tx_state <= c_T_REL;
                    end
                end
                default: begin
                    if (!w_oack_s) r_tx_state <= c_T_IDLE;
                end
            endcase
        end
    end

    // Sticky drop flag; a new drop takes priority over a clear
    always_ff @(posedge clk) begin
        if (reset)              r_drop <= 1'b0;
        else if (w_host_drop)   r_drop <= 1'b1;
        else if (bus.clr_drop)  r_drop <= 1'b0;
    end

    assign bus.lnk_ack     = r_ack;
    assign bus.lnk_oreq    = r_oreq;
    assign bus.lnk_dout    = r_dout;
    assign bus.host_rdata  = r_rx_mem[r_rx_rp[AW-1:0]];
    assign bus.host_rvalid = !w_rx_empty;
    assign bus.host_wfull  = w_tx_full;
    assign bus.tx_drop     = r_drop;
    assign bus.rx_cnt      = r_rx_cnt;
    assign bus.tx_cnt      = r_tx_cnt;

endmodule
`default_nettype wire

// File: doc/gpio_link_peer.md
Name: gpio_link_peer

Overview:
- Hardware responder for the inter-board GPIO parallel byte link. Replaces a second CPU board so a single board can exercise its IN/OUT path in G1/G2 wiring.
- Receives bytes from the remote sender through a four-phase req/ack handshake and buffers them in an RX FIFO for a local host port.
- Transmits host-written bytes back over a second four-phase channel from a TX FIFO.
- Optional echo mode forwards every received byte straight into the TX FIFO.

Parameters:
- DEPTH, 16, entries per FIFO; power of two, minimum 2.
- AW, 4, log2(DEPTH).
- SYNC_STAGES, 2, flip-flop stages on each asynchronous input strobe (lnk_req, lnk_oack); minimum 2.

Ports:
- clk  in  1  system clock (CLOCK_27 domain)
- reset  in  1  synchronous, active-high reset
- lnk_din  in  8  inbound byte from remote board; stable while lnk_req=1
- lnk_req  in  1  inbound request strobe, asynchronous
- lnk_ack  out  1  inbound acknowledge
- lnk_dout  out  8  outbound byte
- lnk_oreq  out  1  outbound request strobe
- lnk_oack  in  1  outbound acknowledge from remote board, asynchronous
- echo  in  1  1 = received bytes go to TX FIFO; RX FIFO and host_wr are bypassed
- host_rd  in  1  pop RX FIFO head
- host_rdata  out  8  RX FIFO head (show-ahead)
- host_rvalid  out  1  RX FIFO non-empty
- host_wr  in  1  push host_wdata into TX FIFO
- host_wdata  in  8  byte to transmit
- host_wfull  out  1  TX FIFO full
- tx_drop  out  1  sticky: a host_wr was issued while TX was full
- clr_drop  in  1  clears tx_drop
- rx_cnt  out  8  bytes accepted from link, mod 256
- tx_cnt  out  8  bytes completed to link, mod 256

Behaviour:
- Reset, one cycle sufficient, legal mid-transfer: both FIFOs empty, both FSMs idle. lnk_ack=0, lnk_oreq=0, lnk_dout=0, tx_drop=0, rx_cnt=0, tx_cnt=0, host_rvalid=0, host_wfull=0. Synchronizer flops clear to 0.
- lnk_req and lnk_oack pass through SYNC_STAGES flops; the FSMs use only the synced values (req_s, oack_s). lnk_din is sampled directly, since the protocol guarantees it is stable.
- RX FSM:
  - R_IDLE: if req_s=1 and the target FIFO is not full (RX FIFO, or TX FIFO when echo=1), capture lnk_din, push it, set lnk_ack=1, increment rx_cnt, go to R_HOLD. If the target is full, stay in R_IDLE with ack low (backpressure; no byte is lost).
  - R_HOLD: wait for req_s=0, then clear lnk_ack and go to R_IDLE.
  - Timing with SYNC_STAGES=2: lnk_ack rises on the 3rd rising edge after lnk_req rises, given setup is met.
- TX FSM:
  - T_IDLE: if the TX FIFO is not empty, pop its head into lnk_dout and go to T_SETUP.
  - T_SETUP: one cycle of data setup, then set lnk_oreq=1 and go to T_REQ.
  - T_REQ: wait for oack_s=1, then clear lnk_oreq, increment tx_cnt, go to T_REL.
  - T_REL: wait for oack_s=0, then go to T_IDLE.
  - lnk_dout holds its value from load until the next load.
- FIFOs:
  - Circular buffer with AW+1-bit pointers. full: pointers differ only in the MSB. empty: pointers are equal.
  - Push and pop in the same cycle: allowed both when empty and when full. On an empty FIFO the push wins and the pop is ignored because rvalid=0. On a full FIFO the pop frees a slot, so the push is accepted; occupancy stays DEPTH.
- Host RX port:
  - host_rdata = RX FIFO head.
  - host_rd with host_rvalid=0 is ignored.
  - A popped byte leaves host_rdata on the next edge.
- Host TX port:
  - host_wr with host_wfull=0 pushes.
  - host_wr with host_wfull=1 is dropped and sets tx_drop.
  - When echo=1, host_wr is ignored entirely and tx_drop is not set.
  - clr_drop clears tx_drop. If clr_drop and a drop occur in the same cycle, the set wins.
- Echo mode:
  - Changing echo only takes effect in R_IDLE. It is latched at the push decision; a transfer in R_HOLD is unaffected.
  - Bytes already in the RX FIFO stay readable by the host.
- Counters wrap 255 -> 0 with no flag.
- Protocol violations are not errors:
  - req dropping while in R_IDLE simply returns to waiting.
  - oack asserted while in T_IDLE/T_SETUP is ignored until T_REQ.

Test Plan:
- Single RX: reset, lnk_din=8'hA5, raise lnk_req -> lnk_ack=1 exactly 3 edges later; host_rvalid=1, host_rdata=8'hA5, rx_cnt=1. Drop lnk_req -> lnk_ack=0 3 edges later.
- RX full backpressure: send 16 bytes 8'h00..8'h0F with no host_rd; start a 17th -> lnk_ack stays 0. One host_rd (data 8'h00) -> the 17th is acked; reading 16 more bytes gives 8'h01..8'h10 in order.
- TX handshake: host_wr 8'h3C -> lnk_dout=8'h3C one cycle before lnk_oreq rises. Remote raises lnk_oack -> lnk_oreq falls, tx_cnt=1. Next byte waits until lnk_oack=0 has synced.
- TX overflow: 17 host_wr with the remote never acking -> host_wfull=1 after the 16th, or the 17th if one byte is already in flight; extra writes set tx_drop=1. clr_drop -> tx_drop=0.
- Echo: echo=1, remote sends 8'h11, 8'h22 -> lnk_dout carries 8'h11 then 8'h22 with full handshakes; host_rvalid remains 0; rx_cnt=tx_cnt=2.
- Reset mid-transfer: assert reset in T_REQ with 3 bytes queued and in R_HOLD -> next cycle lnk_oreq=0, lnk_ack=0, host_rvalid=0, counters 0. After releasing lnk_req/lnk_oack, a new transfer works normally.
